// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared state encoding and constants for the fetch sequencer
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - memory wait-state counter with timeout flag
module fetch_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/ifetch_sequencer.sv
// rtl/ifetch_sequencer.sv - multicycle instruction fetch sequencer feeding the IR
module ifetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] instr_out,
  output logic        ir_w,
  output logic [31:0] pc_out,
  output logic        busy,
  output logic        done,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, pend_pc_q, pend_pc_d;
  logic         rd_q, rd_d, irw_q, irw_d, err_q, err_d, busy_q, pend_q, pend_d;
  logic         tmr_clr, tmr_en, timeout;

  fetch_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!pc_load && fetch_en && pc_q[1:0] == 2'b00) state_d = S_REQ;
      S_REQ:   state_d = mem_ready ? S_WRITE : S_WAIT;
      S_WAIT:  if (mem_ready) state_d = S_WRITE;
               else if (timeout) state_d = S_IDLE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of every registered output; a redirect seen while busy is parked until the fetch ends.
  always_comb begin
    pc_d      = pc_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    rd_d      = 1'b0;
    irw_d     = 1'b0;
    err_d     = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_clr = 1'b1;
        if (pc_load) begin
          pc_d = pc_in;
        end else if (fetch_en) begin
          if (pc_q[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            rd_d   = 1'b1;
            addr_d = pc_q;
          end
        end
      end
      S_REQ, S_WAIT: begin
        if (pc_load) begin
          pend_d    = 1'b1;
          pend_pc_d = pc_in;
        end
        if (mem_ready) begin
          instr_d = mem_rdata;
          irw_d   = 1'b1;
          tmr_clr = 1'b1;
        end else if (state_q == S_WAIT && timeout) begin
          err_d   = 1'b1;
          tmr_clr = 1'b1;
          pend_d  = 1'b0;
          if (pc_load)     pc_d = pc_in;
          else if (pend_q) pc_d = pend_pc_q;
        end else begin
          rd_d   = 1'b1;
          tmr_en = 1'b1;
        end
      end
      S_WRITE: begin
        tmr_clr = 1'b1;
        pend_d  = 1'b0;
        if (pc_load)     pc_d = pc_in;
        else if (pend_q) pc_d = pend_pc_q;
        else             pc_d = pc_q + PC_STEP;
      end
      default: tmr_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      instr_q   <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      rd_q      <= 1'b0;
      irw_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      rd_q      <= rd_d;
      irw_q     <= irw_d;
      err_q     <= err_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign pc_out    = pc_q;
  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign instr_out = instr_q;
  assign ir_w      = irw_q;
  assign done      = irw_q;
  assign fetch_err = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// tb/tb_ifetch_sequencer.sv - directed self-checking bench for ifetch_sequencer
module tb_ifetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_in = '0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] instr_out;
  logic        ir_w;
  logic [31:0] pc_out;
  logic        busy;
  logic        done;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  ifetch_sequencer #(.RESET_PC(32'h0), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_en  (fetch_en),
    .pc_load   (pc_load),
    .pc_in     (pc_in),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .instr_out (instr_out),
    .ir_w      (ir_w),
    .pc_out    (pc_out),
    .busy      (busy),
    .done      (done),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({mem_rd, ir_w, done, fetch_err, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {mem_rd, ir_w, done, fetch_err, busy});
    end
    checks++;
    if (pc_out !== 32'h0 || mem_addr !== 32'h0 || instr_out !== 32'h0) begin
      errors++; $display("FAIL reset_regs pc=%h addr=%h instr=%h exp=0", pc_out, mem_addr, instr_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait(input logic [31:0] start_pc, input logic [31:0] word);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== start_pc || busy !== 1'b1 || ir_w !== 1'b0) begin
      errors++; $display("FAIL zw_req rd=%b addr=%h busy=%b irw=%b exp addr=%h", mem_rd, mem_addr, busy, ir_w, start_pc);
    end
    mem_ready = 1'b1;
    mem_rdata = word;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    checks++;
    if (ir_w !== 1'b1 || done !== 1'b1 || mem_rd !== 1'b0 || instr_out !== word) begin
      errors++; $display("FAIL zw_write irw=%b done=%b rd=%b instr=%h exp instr=%h", ir_w, done, mem_rd, instr_out, word);
    end
    tick();
    checks++;
    if (ir_w !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || pc_out !== start_pc + 32'd4 || instr_out !== word) begin
      errors++; $display("FAIL zw_after irw=%b busy=%b pc=%h exp pc=%h", ir_w, busy, pc_out, start_pc + 32'd4);
    end
  endtask

  task automatic test_wait_wrap();
    pc_load = 1'b1;
    pc_in = 32'hFFFF_FFFC;
    tick();
    pc_load = 1'b0;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req rd=%b addr=%h exp 1 fffffffc", mem_rd, mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 32'hFFFF_FFFC || ir_w !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL wrap_wait%0d rd=%b addr=%h irw=%b busy=%b", i, mem_rd, mem_addr, ir_w, busy);
      end
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h8C09_0010;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (ir_w !== 1'b1 || done !== 1'b1 || mem_rd !== 1'b0 || instr_out !== 32'h8C09_0010) begin
      errors++; $display("FAIL wrap_write irw=%b done=%b rd=%b instr=%h exp 8c090010", ir_w, done, mem_rd, instr_out);
    end
    tick();
    checks++;
    if (pc_out !== 32'h0 || ir_w !== 1'b0) begin
      errors++; $display("FAIL wrap_pc pc=%h irw=%b exp pc=00000000", pc_out, ir_w);
    end
  endtask

  task automatic test_redirect();
    pc_load = 1'b1;
    pc_in = 32'h8;
    fetch_en = 1'b1;
    tick();
    pc_load = 1'b0;
    fetch_en = 1'b0;
    checks++;
    if (pc_out !== 32'h8 || mem_rd !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL redir_prio pc=%h rd=%b busy=%b exp pc=8 rd=0 busy=0", pc_out, mem_rd, busy);
    end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    pc_load = 1'b1;
    pc_in = 32'h40;
    tick();
    pc_load = 1'b0;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h8 || pc_out !== 32'h8) begin
      errors++; $display("FAIL redir_wait rd=%b addr=%h pc=%h exp addr=8 pc=8", mem_rd, mem_addr, pc_out);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h0810_0000;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (ir_w !== 1'b1 || instr_out !== 32'h0810_0000) begin
      errors++; $display("FAIL redir_write irw=%b instr=%h exp 08100000", ir_w, instr_out);
    end
    tick();
    checks++;
    if (pc_out !== 32'h40) begin
      errors++; $display("FAIL redir_pc pc=%h exp 00000040", pc_out);
    end
  endtask

  task automatic test_misaligned();
    pc_load = 1'b1;
    pc_in = 32'h6;
    tick();
    pc_load = 1'b0;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || mem_rd !== 1'b0 || busy !== 1'b0 || pc_out !== 32'h6) begin
      errors++; $display("FAIL mis_err err=%b rd=%b busy=%b pc=%h exp err=1 pc=6", fetch_err, mem_rd, busy, pc_out);
    end
    tick();
    checks++;
    if (fetch_err !== 1'b0 || mem_rd !== 1'b0 || ir_w !== 1'b0 || pc_out !== 32'h6) begin
      errors++; $display("FAIL mis_after err=%b rd=%b irw=%b pc=%h exp 0 0 0 6", fetch_err, mem_rd, ir_w, pc_out);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] old_instr;
    old_instr = 32'h0810_0000;
    pc_load = 1'b1;
    pc_in = 32'h100;
    tick();
    pc_load = 1'b0;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (mem_rd !== 1'b1 || fetch_err !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL tmo_wait%0d rd=%b err=%b busy=%b exp 1 0 1", i, mem_rd, fetch_err, busy);
      end
    end
    tick();
    checks++;
    if (mem_rd !== 1'b0 || fetch_err !== 1'b1 || busy !== 1'b0 || ir_w !== 1'b0) begin
      errors++; $display("FAIL tmo_abort rd=%b err=%b busy=%b irw=%b exp 0 1 0 0", mem_rd, fetch_err, busy, ir_w);
    end
    checks++;
    if (pc_out !== 32'h100 || instr_out !== old_instr) begin
      errors++; $display("FAIL tmo_keep pc=%h instr=%h exp 00000100 %h", pc_out, instr_out, old_instr);
    end
    tick();
    checks++;
    if (fetch_err !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse err=%b exp 0", fetch_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    pc_load = 1'b1;
    pc_in = 32'h20;
    tick();
    pc_load = 1'b0;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_rd, ir_w, done, fetch_err, busy} !== 5'b0 || pc_out !== 32'h0 || mem_addr !== 32'h0 || instr_out !== 32'h0) begin
      errors++; $display("FAIL async_rst flags=%b pc=%h addr=%h instr=%h exp all 0",
                         {mem_rd, ir_w, done, fetch_err, busy}, pc_out, mem_addr, instr_out);
    end
    #1;
    rst = 1'b0;
    tick();
    test_zero_wait(32'h0, 32'h3C01_1234);
  endtask

  initial begin
    test_reset();
    test_zero_wait(32'h0, 32'h2008_0005);
    test_wait_wrap();
    test_redirect();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
